// File: rtl/alu_control_sequencer.sv
// Control-step sequencer for the Datapath: fetch (T0-T2) plus execute (T3-T6)
// of register-class ALU, MUL/DIV and NOP instructions.
module alu_control_sequencer #(
  parameter logic [4:0] NOP_OP = 5'b11010,
  parameter logic [4:0] MUL_OP = 5'b01111,
  parameter logic [4:0] DIV_OP = 5'b10000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  opcode,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  state_t     state;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign is_alu    = (op >= 5'b00011) && (op <= 5'b01010);
  assign is_muldiv = (op == MUL_OP) || (op == DIV_OP);

  function automatic logic [15:0] dec16(input logic [3:0] n);
    dec16    = 16'h0000;
    dec16[n] = 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else begin
      case (state)
        IDLE: if (run) state <= T0;
        T0:   state <= T1;
        T1:   state <= T2;
        T2:   state <= T3;
        T3: begin
          if (is_alu || is_muldiv) state <= T4;
          else if (run)            state <= T0;
          else                     state <= IDLE;
        end
        T4:   state <= T5;
        T5: begin
          if (is_muldiv) state <= T6;
          else if (run)  state <= T0;
          else           state <= IDLE;
        end
        T6: begin
          if (run) state <= T0;
          else     state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Execute-step decode reads ir directly: IR is loaded at the edge ending T2,
  // so a registered decode would see the previous instruction.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; IncPC = 1'b0; Read = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Rout = 16'h0000; Rin = 16'h0000; opcode = NOP_OP;
    done = 1'b0; illegal = 1'b0;
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (is_alu || is_muldiv) begin
          Rout = dec16(ra);
          Yin  = 1'b1;
        end else begin
          done    = 1'b1;
          illegal = (op != NOP_OP);
        end
      end
      T4: begin Rout = dec16(rb); Zin = 1'b1; opcode = op; end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else begin
          Rin  = dec16(rc);
          done = 1'b1;
        end
      end
      T6: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: per-instruction step lists from a reference
// model, a directed instruction table, multi-cycle corner cases and random ops.
module tb_alu_control_sequencer;

  localparam logic [4:0] NOP = 5'b11010;

  logic        clock = 1'b0;
  logic        clear, run;
  logic [31:0] ir;
  logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin;
  logic        Yin, IncPC, Read, HIin, LOin, done, illegal;
  logic [15:0] Rout, Rin;
  logic [4:0]  opcode;

  always #5 clock = ~clock;

  alu_control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .IncPC(IncPC), .Read(Read), .HIin(HIin), .LOin(LOin),
    .Rout(Rout), .Rin(Rin), .opcode(opcode), .done(done), .illegal(illegal)
  );

  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out, mar_in, z_in, pc_in, mdr_in;
    logic ir_in, y_in, inc_pc, read, hi_in, lo_in;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  opcode;
    logic done, illegal;
  } ctl_t;

  typedef struct {
    ctl_t        v;
    bit          first;
    bit          load;
    logic [31:0] irv;
  } step_t;

  typedef struct {
    string       name;
    logic [31:0] irv;
    int          cycles;
    bit          ill;
    logic [15:0] rin_or;
  } vec_t;

  ctl_t act;
  assign act = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                Yin, IncPC, Read, HIin, LOin, Rout, Rin, opcode, done, illegal};

  int          vectors = 0, miscompares = 0, cyc = 0;
  step_t       sq[$];
  logic [31:0] prog[$];
  bit          rand_run = 0, hold_run = 0, seq_arm = 0, ill_seen = 0;
  int          inst_start = 0, done_len = 0, seq_start = 0, seq_end = 0;
  logic [15:0] rin_or = '0;
  vec_t        tbl[9];

  function automatic ctl_t idle_v();
    idle_v        = '0;
    idle_v.opcode = NOP;
  endfunction

  function automatic step_t mk();
    mk.v     = idle_v();
    mk.first = 1'b0;
    mk.load  = 1'b0;
    mk.irv   = '0;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Reference: the whole control-step list of one instruction, built from its class.
  task automatic push_steps(input logic [31:0] irv);
    step_t s;
    logic [4:0] op;
    logic [3:0] a, b, c;
    op = irv[31:27]; a = irv[26:23]; b = irv[22:19]; c = irv[18:15];
    s = mk(); s.first = 1; s.load = 1; s.irv = $urandom;
    s.v.pc_out = 1; s.v.mar_in = 1; s.v.inc_pc = 1; s.v.z_in = 1; sq.push_back(s);
    s = mk(); s.v.zlo_out = 1; s.v.pc_in = 1; s.v.read = 1; s.v.mdr_in = 1; sq.push_back(s);
    s = mk(); s.v.mdr_out = 1; s.v.ir_in = 1; s.load = 1; s.irv = irv; sq.push_back(s);
    if ((op >= 3 && op <= 10) || op == 5'd15 || op == 5'd16) begin
      s = mk(); s.v.rout = 16'd1 << a; s.v.y_in = 1; sq.push_back(s);
      s = mk(); s.v.rout = 16'd1 << b; s.v.z_in = 1; s.v.opcode = op; sq.push_back(s);
      if (op >= 3 && op <= 10) begin
        s = mk(); s.v.zlo_out = 1; s.v.rin = 16'd1 << c; s.v.done = 1; sq.push_back(s);
      end else begin
        s = mk(); s.v.zlo_out = 1; s.v.lo_in = 1; sq.push_back(s);
        s = mk(); s.v.zhi_out = 1; s.v.hi_in = 1; s.v.done = 1; sq.push_back(s);
      end
    end else begin
      s = mk(); s.v.done = 1; s.v.illegal = (op != NOP); sq.push_back(s);
    end
  endtask

  task automatic cycle();
    step_t s;
    @(negedge clock);
    cyc++;
    s = mk();
    if (sq.size() > 0) s = sq.pop_front();
    if (s.first) begin
      inst_start = cyc; rin_or = '0; ill_seen = 0; done_len = 0;
      if (seq_arm) begin seq_start = cyc; seq_arm = 0; end
    end
    check($sformatf("step cyc %0d", cyc), 64'(act), 64'(s.v));
    check($sformatf("onehot cyc %0d", cyc),
          64'($countones(Rout) <= 1 && $countones(Rin) <= 1), 64'd1);
    rin_or |= Rin;
    if (done) begin done_len = cyc - inst_start + 1; ill_seen = illegal; seq_end = cyc; end
    if (s.load) ir = s.irv;
    if (sq.size() == 0) begin
      run = 1'b0;
      if (prog.size() > 0 && (!rand_run || $urandom_range(0, 1) == 1)) begin
        run = 1'b1;
        push_steps(prog.pop_front());
      end
    end else run = rand_run ? 1'($urandom_range(0, 1)) : hold_run;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] op;
    case ($urandom_range(0, 5))
      0, 1, 2: op = 5'($urandom_range(3, 10));
      3:       op = 5'b01111;
      4:       op = 5'b10000;
      default: op = 5'($urandom);
    endcase
    rand_ir = {op, 27'($urandom)};
  endfunction

  initial begin
    tbl[0] = '{"shra",    32'h31188000, 6, 1'b0, 16'h0002};
    tbl[1] = '{"alu03",   32'h18078000, 6, 1'b0, 16'h8000};
    tbl[2] = '{"alu0a",   32'h50000000, 6, 1'b0, 16'h0001};
    tbl[3] = '{"mul",     32'h7A280000, 7, 1'b0, 16'h0000};
    tbl[4] = '{"div",     32'h80B80000, 7, 1'b0, 16'h0000};
    tbl[5] = '{"nop",     32'hD0000000, 4, 1'b0, 16'h0000};
    tbl[6] = '{"ill_1f",  32'hF8000000, 4, 1'b1, 16'h0000};
    tbl[7] = '{"ill_02",  32'h10000000, 4, 1'b1, 16'h0000};
    tbl[8] = '{"ill_0b",  32'h58000000, 4, 1'b1, 16'h0000};

    clear = 1'b1; run = 1'b1; ir = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_idle", 64'(act), 64'(idle_v()));
    clear = 1'b0; run = 1'b0;

    for (int i = 0; i < 9; i++) begin
      prog.push_back(tbl[i].irv);
      repeat (10) cycle();
      check({"cycles_", tbl[i].name},  64'(done_len), 64'(tbl[i].cycles));
      check({"illegal_", tbl[i].name}, 64'(ill_seen), 64'(tbl[i].ill));
      check({"rin_", tbl[i].name},     64'(rin_or),   64'(tbl[i].rin_or));
    end

    // Back-to-back shra with run held: no idle gap between instructions.
    hold_run = 1; seq_arm = 1;
    prog.push_back(32'h31188000); prog.push_back(32'h31188000);
    repeat (16) cycle();
    check("b2b_total", 64'(seq_end - seq_start + 1), 64'd12);
    hold_run = 0;

    // clear during T4 with run still high: sequencer abandons the instruction.
    hold_run = 1;
    prog.push_back(32'h31188000);
    repeat (6) cycle();
    clear = 1'b1; run = 1'b1;
    sq.delete();
    @(negedge clock);
    check("clear_idle", 64'(act), 64'(idle_v()));
    clear = 1'b0; run = 1'b0; hold_run = 0;
    repeat (4) cycle();

    rand_run = 1;
    for (int i = 0; i < 40; i++) prog.push_back(rand_ir());
    for (int g = 0; g < 2000 && (prog.size() > 0 || sq.size() > 0); g++) cycle();
    rand_run = 0; prog.delete();
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Control-step sequencer that drives the Datapath's control inputs for instruction fetch and execution of register-class ALU instructions. It sits directly upstream of the Datapath and replaces hand-written testbench stepping. It reads the Datapath IR contents, walks the fetch steps T0–T2 and the execute steps T3–T6, and asserts the exact per-step control signals the Datapath consumes.

## Interface
Parameters
- NOP_OP, 5'b11010, ALU opcode driven whenever no ALU operation is requested.
- MUL_OP, 5'b01111, multiply opcode; result goes to HI and LO.
- DIV_OP, 5'b10000, divide opcode; result goes to HI and LO.

Ports
- clock  in  1  single system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- run  in  1  level request; start or continue executing instructions.
- ir  in  32  Datapath IR contents. Fields: op=ir[31:27], A=ir[26:23] (source 1), B=ir[22:19] (source 2), C=ir[18:15] (destination).
- PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, HIin, LOin  out  1 each  Datapath strobes.
- Rout  out  16  one-hot register-out enables; bit n drives RnOut.
- Rin  out  16  one-hot register-in enables; bit n drives Rnin.
- opcode  out  5  ALU operation select.
- done  out  1  one-cycle pulse in the last step of each instruction.
- illegal  out  1  one-cycle pulse, coincident with done, for an unsupported op.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Outputs are Moore-decoded from the state register and `ir`. `ir` is used only in T3–T6, where it is stable.
- IDLE: all outputs 0; opcode=NOP_OP.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- Execute steps by instruction class, decided from op in T3:
  - Three-register ALU class (op 00011–01010 inclusive, e.g. shra=00110):
    - T3: Rout[A], Yin.
    - T4: Rout[B], Zin, opcode=op.
    - T5: Zlowout, Rin[C], done.
  - MUL_OP / DIV_OP:
    - T3: Rout[A], Yin.
    - T4: Rout[B], Zin, opcode=op.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin, done.
  - NOP_OP: T3 asserts done only; no register activity.
  - Any other op: behaves as NOP and asserts illegal together with done in T3.
- opcode equals NOP_OP in every state except T4.
- Transitions:
  - IDLE→T0 when run=1; otherwise stay in IDLE.
  - T0→T1→T2→T3 unconditionally.
  - From the last step (T3, T5 or T6, by class): go to T0 if run=1, else IDLE.
  - T3→T4 for the ALU and MUL/DIV classes; T4→T5; T5→T6 only for MUL/DIV.
- Rout/Rin are decoded with a 4-to-16 one-hot decoder. At most one Rout bit and one Rin bit are ever high. Both are 0 outside the listed steps.

## Timing
- Reset: clear=1 at a rising edge forces IDLE. All outputs read 0 (opcode=NOP_OP) in the following cycle. clear takes priority over run and over any in-flight step. A partially executed instruction is abandoned, with no register write after the reset edge.
- Latency, counted from the first edge with run=1 in IDLE:
  - T0 is active for the next cycle.
  - An ALU instruction completes in 6 cycles (T0–T5).
  - MUL/DIV completes in 7 cycles.
  - NOP or illegal completes in 4 cycles.
- Back-to-back: with run held high, T0 of the next instruction immediately follows done, with zero idle cycles.
- Dropping run mid-instruction does not abort. The instruction completes and the sequencer then returns to IDLE.
- `ir` changes at the edge ending T2. The sequencer never samples `ir` in T0–T2.

## Test plan
- Three-register ALU (shra): ir=0x31188000, run pulsed for 1 cycle.
  - Fetch steps match T0–T2 above.
  - T3: Rout=0x0004, Yin=1.
  - T4: Rout=0x0008, opcode=00110, Zin=1.
  - T5: Zlowout=1, Rin=0x0002, done=1.
  - Then IDLE.
- MUL: ir op=01111, A=4, B=5.
  - T5: LOin=1, Zlowout=1.
  - T6: HIin=1, Zhighout=1, done=1; Rin stays 0 throughout.
- NOP and illegal: ir op=11010 gives done in T3 with illegal=0. op=11111 gives done=1 and illegal=1 in T3.
- Back-to-back: run held high for two shra instructions. The second T0 immediately follows the first T5; total 12 cycles.
- Reset mid-operation: clear asserted during T4.
  - Next cycle: IDLE, all outputs 0, opcode=11010.
  - No Rin pulse occurs.
- One-hot check: across a full random-op run, Rout and Rin are checked every cycle to have popcount ≤1.
